// File: rtl/mxu_pkg.sv
// -----------------------------------------------------------------------------
// mxu_pkg
// Shared definitions for the MXU sequencer slice.
//   mxu_state_e   : sequencer FSM states
//   TARGET_Y_NONE : load_weight_target_y value that matches no array row
//   MXU_DATA_W    : default signed weight/activation width
//   MXU_ACC_W     : default signed partial-sum/result width
// -----------------------------------------------------------------------------
package mxu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } mxu_state_e;

  localparam logic [7:0] TARGET_Y_NONE = 8'hFF;
  localparam int         MXU_DATA_W    = 8;
  localparam int         MXU_ACC_W     = 24;

endpackage

// File: rtl/mxu_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// mxu_seq_ctrl_if
// Feeder/result streams of the MXU sequencer.
//   w_valid/w_ready/w_row   : weight rows, COLS*DATA_W, column 0 in LSBs
//   a_valid/a_ready/a_vec   : activation vectors, ROWS*DATA_W, row 0 in LSBs
//   res_valid/res_data      : deskewed result rows, COLS*ACC_W, no backpressure
// Modports:
//   master : the feeder / result consumer side
//   slave  : the sequencer (mxu_seq_ctrl)
// -----------------------------------------------------------------------------
interface mxu_seq_ctrl_if
  import mxu_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = MXU_DATA_W,
  parameter int ACC_W  = MXU_ACC_W
) ();

  logic                   w_valid;
  logic                   w_ready;
  logic [COLS*DATA_W-1:0] w_row;

  logic                   a_valid;
  logic                   a_ready;
  logic [ROWS*DATA_W-1:0] a_vec;

  logic                   res_valid;
  logic [COLS*ACC_W-1:0]  res_data;

  modport master (
    output w_valid, w_row, a_valid, a_vec,
    input  w_ready, a_ready, res_valid, res_data
  );

  modport slave (
    input  w_valid, w_row, a_valid, a_vec,
    output w_ready, a_ready, res_valid, res_data
  );

endinterface

// File: rtl/mxu_deskew.sv
// -----------------------------------------------------------------------------
// mxu_deskew
// Realigns the staggered bottom-row column results of the PE array into whole
// result rows. Column c is delayed by COLS-1-c cycles and then registered once
// more, so every column of one vector appears in the same output cycle.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_col_data   : COLS*ACC_W bottom-row results from the array
//   o_row_data   : COLS*ACC_W aligned result row, column 0 in LSBs
// -----------------------------------------------------------------------------
module mxu_deskew
  import mxu_pkg::*;
#(
  parameter int COLS  = 4,
  parameter int ACC_W = MXU_ACC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLS*ACC_W-1:0] i_col_data,
  output logic [COLS*ACC_W-1:0] o_row_data
);

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    localparam int DEPTH = COLS - 1 - gi;
    logic [ACC_W-1:0] r_out;

    if (DEPTH == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (rst) begin
          r_out <= '0;
        end else begin
          r_out <= i_col_data[gi*ACC_W +: ACC_W];
        end
      end
    end else begin : g_delay
      logic [ACC_W-1:0] r_sh [DEPTH];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) r_sh[k] <= '0;
          r_out <= '0;
        end else begin
          r_sh[0] <= i_col_data[gi*ACC_W +: ACC_W];
          for (int k = 1; k < DEPTH; k++) r_sh[k] <= r_sh[k-1];
          r_out <= r_sh[DEPTH-1];
        end
      end
    end

    assign o_row_data[gi*ACC_W +: ACC_W] = r_out;
  end

endmodule

// File: rtl/mxu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mxu_seq_ctrl
// Sequencer for a systolic MXU: loads a ROWS x COLS weight tile row by row,
// streams activation vectors into the array with per-row skew and emits the
// deskewed COLS-wide result rows in acceptance order.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, num_vecs   : begin a job of num_vecs vectors (sampled in IDLE only)
//   abort             : abandon the job, back to IDLE, no done pulse
//   busy, done        : busy in every non-IDLE state, done = 1-cycle pulse
//   bus (slave)       : weight stream, activation stream, result stream
//   arr_load_phase    : array load_phase
//   arr_target_y      : array load_weight_target_y (8'hFF = no row)
//   arr_load_weight   : array top-edge load_weight
//   arr_act           : skewed activations into column 0 of each row
//   arr_psum_top      : top-row partial sum, constant 0
//   arr_result        : bottom-row results from the array
// Build option MXU_CTRL_STALL_CNT_EN adds stall_cnt / job_cycles counters.
// -----------------------------------------------------------------------------
module mxu_seq_ctrl
  import mxu_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = MXU_DATA_W,
  parameter int ACC_W  = MXU_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            num_vecs,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  mxu_seq_ctrl_if.slave          bus,
  output logic                   arr_load_phase,
  output logic [7:0]             arr_target_y,
  output logic [COLS*DATA_W-1:0] arr_load_weight,
  output logic [ROWS*DATA_W-1:0] arr_act,
  output logic [COLS*ACC_W-1:0]  arr_psum_top,
  input  logic [COLS*ACC_W-1:0]  arr_result
`ifdef MXU_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            job_cycles
`endif
);

  localparam int DRAIN_CYCLES = ROWS + COLS;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES);
  localparam int PIPE_LEN     = ROWS + COLS;

  mxu_state_e       r_state;
  mxu_state_e       w_state_next;
  logic [15:0]      r_num_vecs;
  logic [7:0]       r_row_cnt;
  logic [15:0]      r_vec_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [PIPE_LEN-1:0] r_vpipe;

  logic w_busy;
  logic w_w_acc;
  logic w_a_acc;
  logic w_flush;
  logic [COLS*ACC_W-1:0] w_res_data;

  assign w_busy  = (r_state != ST_IDLE);
  assign w_w_acc = (r_state == ST_LOAD_W) && bus.w_valid;
  assign w_a_acc = (r_state == ST_COMPUTE) && bus.a_valid;
  // Abort empties the in-flight pipes so no stale result row escapes later.
  assign w_flush = abort && w_busy;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    busy            = w_busy;
    done            = 1'b0;
    bus.w_ready     = 1'b0;
    bus.a_ready     = 1'b0;
    arr_load_phase  = 1'b0;
    arr_target_y    = 8'h00;
    arr_load_weight = '0;

    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        arr_load_phase = 1'b1;
        bus.w_ready    = 1'b1;
        // Without a valid row no array row may match the target.
        if (bus.w_valid) begin
          arr_target_y    = r_row_cnt;
          arr_load_weight = bus.w_row;
          if (r_row_cnt == 8'(ROWS - 1)) begin
            w_state_next = (r_num_vecs == 16'd0) ? ST_DONE : ST_COMPUTE;
          end
        end else begin
          arr_target_y = TARGET_Y_NONE;
        end
      end
      ST_COMPUTE: begin
        bus.a_ready = 1'b1;
        if (w_a_acc && (r_vec_cnt == r_num_vecs - 16'd1)) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_flush) w_state_next = ST_IDLE;
  end

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_vecs  <= 16'd0;
      r_row_cnt   <= 8'd0;
      r_vec_cnt   <= 16'd0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num_vecs  <= num_vecs;
            r_row_cnt   <= 8'd0;
            r_vec_cnt   <= 16'd0;
            r_drain_cnt <= '0;
          end
        end
        ST_LOAD_W:  if (w_w_acc) r_row_cnt <= r_row_cnt + 8'd1;
        ST_COMPUTE: if (w_a_acc) r_vec_cnt <= r_vec_cnt + 16'd1;
        ST_DRAIN:   r_drain_cnt <= r_drain_cnt + 1'b1;
        default:    ;
      endcase
    end
  end

  // ---------------------------------------------------------------- skew
  // Row r holds r+1 stages, so a vector accepted at T reaches row r at T+1+r.
  // Idle cycles shift in zeros (bubbles).
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew
    logic [DATA_W-1:0] r_sk [gi+1];
    always_ff @(posedge clk) begin
      if (rst || w_flush) begin
        for (int k = 0; k <= gi; k++) r_sk[k] <= '0;
      end else begin
        r_sk[0] <= w_a_acc ? bus.a_vec[gi*DATA_W +: DATA_W] : '0;
        for (int k = 1; k <= gi; k++) r_sk[k] <= r_sk[k-1];
      end
    end
    assign arr_act[gi*DATA_W +: DATA_W] = r_sk[gi];
  end

  // ---------------------------------------------------------------- valid pipe
  // Tracks accepted vectors through skew + array + deskew latency (ROWS+COLS).
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe <= {r_vpipe[PIPE_LEN-2:0], w_a_acc};
    end
  end

  mxu_deskew #(
    .COLS  (COLS),
    .ACC_W (ACC_W)
  ) u_deskew (
    .clk        (clk),
    .rst        (rst),
    .i_col_data (arr_result),
    .o_row_data (w_res_data)
  );

  assign bus.res_valid = r_vpipe[PIPE_LEN-1];
  assign bus.res_data  = w_res_data;
  assign arr_psum_top  = '0;

`ifdef MXU_CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= 32'd0;
      job_cycles <= 32'd0;
    end else if ((r_state == ST_IDLE) && start) begin
      stall_cnt  <= 32'd0;
      job_cycles <= 32'd0;
    end else begin
      if (w_busy) job_cycles <= job_cycles + 32'd1;
      if ((r_state == ST_COMPUTE) && !bus.a_valid) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
